// File: rtl/wb_stage.sv
// RV32I writeback stage.
// Formats load data, selects the writeback result and drives the register-file
// write port combinationally. Also holds a one-cycle WB->ID bypass register,
// free-running cycle / retired-instruction counters and a sticky flag that
// records any misaligned load reaching this stage.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ValidW,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic [2:0]       LoadControlW,
    input  logic [4:0]       rdW,
    input  logic [XLEN-1:0]  ALUResultW,
    input  logic [XLEN-1:0]  PCPlus4W,
    input  logic [XLEN-1:0]  PCTargetW,
    input  logic [XLEN-1:0]  ReadDataW,
    output logic             RfWeW,
    output logic [4:0]       RfAddrW,
    output logic [XLEN-1:0]  ResultW,
    output logic             BypValid,
    output logic [4:0]       BypRd,
    output logic [XLEN-1:0]  BypData,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstretCnt,
    output logic             MisalignFlag
);

    // Result-source selector encodings.
    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;
    localparam logic [1:0] SRC_TGT  = 2'b11;

    // Load funct3 encodings.
    localparam logic [2:0] LC_LB  = 3'b000;
    localparam logic [2:0] LC_LH  = 3'b001;
    localparam logic [2:0] LC_LW  = 3'b010;
    localparam logic [2:0] LC_LBU = 3'b100;
    localparam logic [2:0] LC_LHU = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Selects byte lane 'off' of an aligned word.
    function automatic logic [7:0] pick_byte(input logic [XLEN-1:0] word,
                                             input logic [1:0]      off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // Selects the lower or upper halfword of an aligned word.
    function automatic logic [15:0] pick_half(input logic [XLEN-1:0] word,
                                              input logic            upper);
        logic [15:0] h;
        if (upper) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        return h;
    endfunction

    // Extends a byte to XLEN, sign-extending when 'sgn' is set.
    function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b,
                                                 input logic       sgn);
        logic [XLEN-1:0] r;
        if (sgn) begin
            r = {{(XLEN-8){b[7]}}, b};
        end else begin
            r = {{(XLEN-8){1'b0}}, b};
        end
        return r;
    endfunction

    // Extends a halfword to XLEN, sign-extending when 'sgn' is set.
    function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h,
                                                 input logic        sgn);
        logic [XLEN-1:0] r;
        if (sgn) begin
            r = {{(XLEN-16){h[15]}}, h};
        end else begin
            r = {{(XLEN-16){1'b0}}, h};
        end
        return r;
    endfunction

    logic [1:0]       off_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic [XLEN-1:0]  load_data_s;
    logic             is_load_s;
    logic             misalign_s;
    logic [XLEN-1:0]  result_s;
    logic             rf_we_s;
    logic             retire_s;

    logic             byp_valid_r;
    logic [4:0]       byp_rd_r;
    logic [XLEN-1:0]  byp_data_r;
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] instret_cnt_r;
    logic             misalign_flag_r;

    // Load data formatting: extract the addressed lane and extend it.
    always_comb begin
        off_s       = ALUResultW[1:0];
        byte_s      = pick_byte(ReadDataW, off_s);
        half_s      = pick_half(ReadDataW, off_s[1]);
        load_data_s = ReadDataW;
        case (LoadControlW)
            LC_LB:   load_data_s = ext_byte(byte_s, 1'b1);
            LC_LBU:  load_data_s = ext_byte(byte_s, 1'b0);
            LC_LH:   load_data_s = ext_half(half_s, 1'b1);
            LC_LHU:  load_data_s = ext_half(half_s, 1'b0);
            LC_LW:   load_data_s = ReadDataW;
            default: load_data_s = ReadDataW;
        endcase
    end

    // Misaligned-load detection; only a real, writing load can be misaligned.
    always_comb begin
        is_load_s  = ValidW & RegWriteW & (ResultSrcW == SRC_LOAD);
        misalign_s = 1'b0;
        case (LoadControlW)
            LC_LH:   misalign_s = is_load_s & off_s[0];
            LC_LHU:  misalign_s = is_load_s & off_s[0];
            LC_LW:   misalign_s = is_load_s & (off_s != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    // Writeback result mux; evaluated whether or not the slot is valid.
    always_comb begin
        result_s = ALUResultW;
        case (ResultSrcW)
            SRC_ALU:  result_s = ALUResultW;
            SRC_LOAD: result_s = load_data_s;
            SRC_PC4:  result_s = PCPlus4W;
            SRC_TGT:  result_s = PCTargetW;
            default:  result_s = ALUResultW;
        endcase
    end

    // Write-enable and retire qualification; x0 is never written and a
    // misaligned load neither writes nor retires.
    always_comb begin
        rf_we_s  = ValidW & RegWriteW & (rdW != 5'd0) & ~misalign_s;
        retire_s = ValidW & ~misalign_s;
    end

    assign RfWeW        = rf_we_s;
    assign RfAddrW      = rdW;
    assign ResultW      = result_s;
    assign BypValid     = byp_valid_r;
    assign BypRd        = byp_rd_r;
    assign BypData      = byp_data_r;
    assign CycleCnt     = cycle_cnt_r;
    assign InstretCnt   = instret_cnt_r;
    assign MisalignFlag = misalign_flag_r;

    // Free-running cycle counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_cnt_r <= {CNT_W{1'b0}};
        end else begin
            cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
        end
    end

    // Retired-instruction counter, including instructions that do not write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            instret_cnt_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instret_cnt_r <= instret_cnt_r + CNT_ONE;
        end else begin
            instret_cnt_r <= instret_cnt_r;
        end
    end

    // Bypass register: valid tracks this cycle's write; rd/data hold the
    // most recent write so a bubble leaves the last value visible.
    always_ff @(posedge CLK) begin
        if (RST) begin
            byp_valid_r <= 1'b0;
            byp_rd_r    <= 5'd0;
            byp_data_r  <= {XLEN{1'b0}};
        end else begin
            byp_valid_r <= rf_we_s;
            if (rf_we_s) begin
                byp_rd_r   <= rdW;
                byp_data_r <= result_s;
            end else begin
                byp_rd_r   <= byp_rd_r;
                byp_data_r <= byp_data_r;
            end
        end
    end

    // Sticky misaligned-load flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            misalign_flag_r <= 1'b0;
        end else begin
            misalign_flag_r <= misalign_flag_r | misalign_s;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a default (64-bit counter) instance and an
// 8-bit counter instance share all inputs. The stimulus process pushes the
// expected per-cycle response from a behavioural model; a monitor pops and
// compares one entry after every rising edge.
module tb_wb_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ValidW = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [1:0]  ResultSrcW = 2'b00;
    logic [2:0]  LoadControlW = 3'b000;
    logic [4:0]  rdW = 5'd0;
    logic [31:0] ALUResultW = 32'h0;
    logic [31:0] PCPlus4W = 32'h0;
    logic [31:0] PCTargetW = 32'h0;
    logic [31:0] ReadDataW = 32'h0;

    logic        RfWeW, BypValid, MisalignFlag;
    logic [4:0]  RfAddrW, BypRd;
    logic [31:0] ResultW, BypData;
    logic [63:0] CycleCnt, InstretCnt;

    logic        RfWeW8, BypValid8, MisalignFlag8;
    logic [4:0]  RfAddrW8, BypRd8;
    logic [31:0] ResultW8, BypData8;
    logic [7:0]  CycleCnt8, InstretCnt8;

    wb_stage dut (
        .CLK(CLK), .RST(RST), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .LoadControlW(LoadControlW), .rdW(rdW),
        .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .PCTargetW(PCTargetW),
        .ReadDataW(ReadDataW), .RfWeW(RfWeW), .RfAddrW(RfAddrW), .ResultW(ResultW),
        .BypValid(BypValid), .BypRd(BypRd), .BypData(BypData),
        .CycleCnt(CycleCnt), .InstretCnt(InstretCnt), .MisalignFlag(MisalignFlag)
    );

    wb_stage #(.XLEN(32), .CNT_W(8)) dut8 (
        .CLK(CLK), .RST(RST), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .LoadControlW(LoadControlW), .rdW(rdW),
        .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .PCTargetW(PCTargetW),
        .ReadDataW(ReadDataW), .RfWeW(RfWeW8), .RfAddrW(RfAddrW8), .ResultW(ResultW8),
        .BypValid(BypValid8), .BypRd(BypRd8), .BypData(BypData8),
        .CycleCnt(CycleCnt8), .InstretCnt(InstretCnt8), .MisalignFlag(MisalignFlag8)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] result;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic [63:0] cyc;
        logic [63:0] ret;
        logic        flag;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference state: what the architectural counters/bypass should hold.
    logic [63:0] m_cyc = 64'd0;
    logic [63:0] m_ret = 64'd0;
    logic        m_bv = 1'b0;
    logic [4:0]  m_brd = 5'd0;
    logic [31:0] m_bd = 32'd0;
    logic        m_flag = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Formats a load the way the ISA defines it, using plain shifts/masks.
    function automatic logic [31:0] ref_load(input logic [2:0] lc, input logic [31:0] rdata,
                                             input int off);
        logic [31:0] b, h;
        b = (rdata >> (8 * off)) & 32'h0000_00FF;
        h = (rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (lc)
            3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return rdata;
        endcase
    endfunction

    // Drive one WB slot at the falling edge and push its expected response.
    task automatic drive(input logic rst, input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] lc, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] pct, input logic [31:0] rdata);
        exp_t e;
        int   off;
        logic mis;
        @(negedge CLK);
        RST = rst; ValidW = v; RegWriteW = rw; ResultSrcW = src; LoadControlW = lc;
        rdW = rd; ALUResultW = alu; PCPlus4W = pc4; PCTargetW = pct; ReadDataW = rdata;

        off = int'(alu % 32'd4);
        mis = 1'b0;
        if (v && rw && src == 2'b01) begin
            if ((lc == 3'b001 || lc == 3'b101) && (off % 2 == 1)) mis = 1'b1;
            if (lc == 3'b010 && off != 0) mis = 1'b1;
        end
        case (src)
            2'b00:   e.result = alu;
            2'b01:   e.result = ref_load(lc, rdata, off);
            2'b10:   e.result = pc4;
            default: e.result = pct;
        endcase
        e.we   = v && rw && (rd != 5'd0) && !mis;
        e.addr = rd;

        if (rst) begin
            m_cyc = 64'd0; m_ret = 64'd0; m_bv = 1'b0; m_brd = 5'd0; m_bd = 32'd0; m_flag = 1'b0;
        end else begin
            m_cyc = m_cyc + 64'd1;
            if (v && !mis) m_ret = m_ret + 64'd1;
            m_bv = e.we;
            if (e.we) begin
                m_brd = rd;
                m_bd  = e.result;
            end
            if (mis) m_flag = 1'b1;
        end
        e.bv = m_bv; e.brd = m_brd; e.bd = m_bd;
        e.cyc = m_cyc; e.ret = m_ret; e.flag = m_flag;
        exp_q.push_back(e);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
        drive(1'b0, 1'b1, 1'b1, 2'b00, 3'b010, rd, val, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: after each rising edge, compare the DUT against the next entry.
    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("RfWeW",        {63'd0, RfWeW},         {63'd0, e.we});
            chk("RfAddrW",      {59'd0, RfAddrW},       {59'd0, e.addr});
            chk("ResultW",      {32'd0, ResultW},       {32'd0, e.result});
            chk("BypValid",     {63'd0, BypValid},      {63'd0, e.bv});
            chk("BypRd",        {59'd0, BypRd},         {59'd0, e.brd});
            chk("BypData",      {32'd0, BypData},       {32'd0, e.bd});
            chk("CycleCnt",     CycleCnt,               e.cyc);
            chk("InstretCnt",   InstretCnt,             e.ret);
            chk("MisalignFlag", {63'd0, MisalignFlag},  {63'd0, e.flag});
            chk("CycleCnt8",    {56'd0, CycleCnt8},     {56'd0, e.cyc[7:0]});
            chk("InstretCnt8",  {56'd0, InstretCnt8},   {56'd0, e.ret[7:0]});
            chk("BypData8",     {32'd0, BypData8},      {32'd0, e.bd});
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        // Reset held for three cycles, then release.
        repeat (3) drive(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        bubble();
        bubble();

        // Byte/half formatting of 0x80FF7F01.
        drive(1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 5'd3, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_7F01);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 3'b100, 5'd3, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_7F01);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 3'b101, 5'd4, 32'h0000_1002, 32'h0, 32'h0, 32'h80FF_7F01);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 3'b001, 5'd4, 32'h0000_1000, 32'h0, 32'h0, 32'h80FF_7F01);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 3'b010, 5'd6, 32'h0000_1000, 32'h0, 32'h0, 32'h80FF_7F01);

        // Misaligned LH: no write, no retire, flag sticks.
        drive(1'b0, 1'b1, 1'b1, 2'b01, 3'b001, 5'd5, 32'h0000_2001, 32'h0, 32'h0, 32'h1234_5678);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 3'b010, 5'd5, 32'h0000_2002, 32'h0, 32'h0, 32'h1234_5678);
        bubble();
        alu_op(5'd9, 32'h0000_0099);

        // Write to x0 retires but does not write.
        drive(1'b0, 1'b1, 1'b1, 2'b10, 3'b000, 5'd0, 32'h0, 32'h0000_0104, 32'h0, 32'h0);

        // Back-to-back writes to rd=7, then a bubble.
        alu_op(5'd7, 32'h0000_0011);
        alu_op(5'd7, 32'h0000_0022);
        bubble();
        bubble();

        // Reset clears the sticky flag; then run past the 8-bit wrap.
        drive(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 262; i++) alu_op(5'd1, i);

        // Reset arriving with a load in WB: nothing retires, counters cleared.
        drive(1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd2, 32'h0000_3000, 32'h0, 32'h0, 32'hCAFE_F00D);
        bubble();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), rd,
                  $urandom, $urandom, $urandom, $urandom);
        end

        // Allow the monitor to drain the scoreboard, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge CLK);
            #2;
        end
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
